// File: rtl/config_pkg.sv
// Shared types and register map for the channelised config CSR bank.
package config_pkg;

  typedef logic [31:0] paddr_t;
  typedef logic [31:0] data_t;
  typedef logic [7:0]  size_t;

  typedef enum logic {
    TXN_READ  = 1'b0,
    TXN_WRITE = 1'b1
  } transaction_t;

  typedef enum logic [1:0] {
    REQ_LOAD     = 2'd0,
    REQ_STORE    = 2'd1,
    REQ_ATOMIC   = 2'd2,
    REQ_PREFETCH = 2'd3
  } req_type_t;

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_PEND   = 2'd1,
    CH_ACTIVE = 2'd2
  } ch_state_t;

  // Offsets within one channel window
  localparam paddr_t OFF_ADDR   = 32'h00;
  localparam paddr_t OFF_OP     = 32'h04;
  localparam paddr_t OFF_SIZE   = 32'h08;
  localparam paddr_t OFF_START  = 32'h0C;
  localparam paddr_t OFF_STATUS = 32'h10;
  localparam paddr_t OFF_IRQ_EN = 32'h14;

  localparam int unsigned STATUS_ERR_BIT = 2;
  localparam int unsigned STATUS_IRQ_BIT = 3;

endpackage

// File: rtl/config_csr_channel.sv
// One transaction channel: ADDR/OP/SIZE registers, launch FSM, sticky error.
// IRQ_EN register and irq_pend only exist when CONFIG_CSR_BANK_IRQ_EN is defined.
//
// state     | meaning
// CH_IDLE   | registers writable, waiting for START
// CH_PEND   | txn_valid high, fields frozen, waiting for txn_ready
// CH_ACTIVE | accepted downstream, waiting for txn_done
module config_csr_channel
  import config_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      wr_en,
  input  paddr_t    wr_off,
  input  data_t     wr_data,
  input  logic      txn_ready,
  input  logic      txn_done,
  output logic      txn_valid,
  output paddr_t    txn_addr,
  output req_type_t txn_op,
  output size_t     txn_size,
  output ch_state_t state,
  output logic      err,
  output logic      irq_pend,
  output logic      irq_en
);

  logic idle;
  logic field_wr;

  assign idle     = (state == CH_IDLE);
  assign field_wr = wr_en && (wr_off == OFF_ADDR || wr_off == OFF_OP ||
                              wr_off == OFF_SIZE || wr_off == OFF_START);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CH_IDLE;
      txn_valid <= 1'b0;
      txn_addr  <= '0;
      txn_op    <= REQ_LOAD;
      txn_size  <= '0;
      err       <= 1'b0;
    end else begin
      if (field_wr && !idle)
        err <= 1'b1;
      else if (wr_en && wr_off == OFF_STATUS && wr_data[STATUS_ERR_BIT])
        err <= 1'b0;

      // Fields only move in IDLE, so they stay frozen through PEND/ACTIVE
      if (wr_en && idle) begin
        case (wr_off)
          OFF_ADDR: txn_addr <= wr_data;
          OFF_OP:   txn_op   <= req_type_t'(wr_data[1:0]);
          OFF_SIZE: txn_size <= wr_data[7:0];
          default:  ;
        endcase
      end

      case (state)
        CH_IDLE:
          if (wr_en && wr_off == OFF_START && wr_data[0]) begin
            state     <= CH_PEND;
            txn_valid <= 1'b1;
          end
        CH_PEND:
          if (txn_ready) begin
            state     <= CH_ACTIVE;
            txn_valid <= 1'b0;
          end
        CH_ACTIVE:
          if (txn_done) state <= CH_IDLE;
        default: begin
          state     <= CH_IDLE;
          txn_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONFIG_CSR_BANK_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_pend <= 1'b0;
      irq_en   <= 1'b0;
    end else begin
      if (wr_en && wr_off == OFF_IRQ_EN) irq_en <= wr_data[0];
      // A completion in the same cycle as a clear keeps the new event
      if (state == CH_ACTIVE && txn_done)
        irq_pend <= 1'b1;
      else if (wr_en && wr_off == OFF_STATUS && wr_data[STATUS_IRQ_BIT])
        irq_pend <= 1'b0;
    end
  end
`else
  assign irq_pend = 1'b0;
  assign irq_en   = 1'b0;
`endif

endmodule

// File: rtl/config_csr_bank.sv
// Config CSR bank: address decode into NUM_CH channel windows plus registered read mux.
// Optional irq output and IRQ_EN register enabled by CONFIG_CSR_BANK_IRQ_EN.
module config_csr_bank
  import config_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter logic [11:0] CH_STRIDE = 12'h020
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  input  paddr_t                  cfg_addr,
  input  data_t                   cfg_data,
  input  size_t                   cfg_size,
  input  transaction_t            cfg_type,
  output data_t                   cfg_read_data,
  output logic                    cfg_read_valid,
  output logic [NUM_CH-1:0]       txn_valid,
  input  logic [NUM_CH-1:0]       txn_ready,
  output paddr_t [NUM_CH-1:0]     txn_addr,
  output req_type_t [NUM_CH-1:0]  txn_op,
  output size_t [NUM_CH-1:0]      txn_size,
  input  logic [NUM_CH-1:0]       txn_done
`ifdef CONFIG_CSR_BANK_IRQ_EN
  ,
  output logic [NUM_CH-1:0]       irq
`endif
);

  localparam paddr_t STRIDE = paddr_t'(CH_STRIDE);

  paddr_t            ch_sel;
  paddr_t            ch_off;
  logic              cfg_wr;
  logic              cfg_rd;
  data_t             rd_mux;
  ch_state_t         ch_state [NUM_CH];
  logic [NUM_CH-1:0] ch_err;
  logic [NUM_CH-1:0] ch_irq_pend;
  logic [NUM_CH-1:0] ch_irq_en;
  logic              unused_cfg_size;

  // Access width is not needed: every register is a full-word location
  assign unused_cfg_size = ^cfg_size;

  assign ch_sel = cfg_addr / STRIDE;
  assign ch_off = cfg_addr % STRIDE;
  assign cfg_wr = cfg_valid && (cfg_type == TXN_WRITE);
  assign cfg_rd = cfg_valid && (cfg_type == TXN_READ);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    config_csr_channel u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (cfg_wr && (ch_sel == paddr_t'(c))),
      .wr_off    (ch_off),
      .wr_data   (cfg_data),
      .txn_ready (txn_ready[c]),
      .txn_done  (txn_done[c]),
      .txn_valid (txn_valid[c]),
      .txn_addr  (txn_addr[c]),
      .txn_op    (txn_op[c]),
      .txn_size  (txn_size[c]),
      .state     (ch_state[c]),
      .err       (ch_err[c]),
      .irq_pend  (ch_irq_pend[c]),
      .irq_en    (ch_irq_en[c])
    );
  end

`ifdef CONFIG_CSR_BANK_IRQ_EN
  assign irq = ch_irq_pend & ch_irq_en;
`else
  logic unused_irq_en;
  assign unused_irq_en = |ch_irq_en;
`endif

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel == paddr_t'(c)) begin
        case (ch_off)
          OFF_ADDR:   rd_mux = txn_addr[c];
          OFF_OP:     rd_mux = data_t'(txn_op[c]);
          OFF_SIZE:   rd_mux = data_t'(txn_size[c]);
          OFF_STATUS: rd_mux = data_t'({ch_irq_pend[c], ch_err[c], ch_state[c]});
`ifdef CONFIG_CSR_BANK_IRQ_EN
          OFF_IRQ_EN: rd_mux = data_t'(ch_irq_en[c]);
`endif
          default:    rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_read_valid <= 1'b0;
      cfg_read_data  <= '0;
    end else begin
      cfg_read_valid <= cfg_rd;
      cfg_read_data  <= cfg_rd ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_config_csr_bank.sv
// Self-checking bench for config_csr_bank: per-cycle model compare plus directed literal checks.
module tb_config_csr_bank;
  import config_pkg::*;

  localparam int          NCH    = 4;
  localparam int unsigned STRIDE = 32'h20;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cfg_valid;
  paddr_t              cfg_addr;
  data_t               cfg_data;
  size_t               cfg_size;
  transaction_t        cfg_type;
  data_t               cfg_read_data;
  logic                cfg_read_valid;
  logic [NCH-1:0]      txn_valid;
  logic [NCH-1:0]      txn_ready;
  paddr_t [NCH-1:0]    txn_addr;
  req_type_t [NCH-1:0] txn_op;
  size_t [NCH-1:0]     txn_size;
  logic [NCH-1:0]      txn_done;
`ifdef CONFIG_CSR_BANK_IRQ_EN
  logic [NCH-1:0]      irq;
`endif

  config_csr_bank #(.NUM_CH(NCH), .CH_STRIDE(12'h020)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_valid      (cfg_valid),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .cfg_size       (cfg_size),
    .cfg_type       (cfg_type),
    .cfg_read_data  (cfg_read_data),
    .cfg_read_valid (cfg_read_valid),
    .txn_valid      (txn_valid),
    .txn_ready      (txn_ready),
    .txn_addr       (txn_addr),
    .txn_op         (txn_op),
    .txn_size       (txn_size),
    .txn_done       (txn_done)
`ifdef CONFIG_CSR_BANK_IRQ_EN
    ,
    .irq            (irq)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  // Behavioural model: register contents and channel phase (0 idle, 1 pending, 2 active)
  logic [31:0] m_addr [NCH];
  logic [31:0] m_op   [NCH];
  logic [31:0] m_size [NCH];
  int          m_state[NCH];
  int          m_pre  [NCH];
  bit          m_err  [NCH];
  bit          m_irqp [NCH];
  bit          m_irqen[NCH];
  bit          exp_rv = 1'b0;
  logic [31:0] exp_rd = '0;
  int unsigned mch, moff;

  function automatic logic [31:0] m_read(int unsigned ch, int unsigned off);
    if (ch >= NCH) return 32'h0;
    case (off)
      32'h00: return m_addr[ch];
      32'h04: return m_op[ch];
      32'h08: return m_size[ch];
      32'h10: return m_state[ch] + (m_err[ch] ? 4 : 0) + (m_irqp[ch] ? 8 : 0);
`ifdef CONFIG_CSR_BANK_IRQ_EN
      32'h14: return {31'd0, m_irqen[ch]};
`endif
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_addr[c] = 0; m_op[c] = 0; m_size[c] = 0; m_state[c] = 0;
        m_err[c] = 0; m_irqp[c] = 0; m_irqen[c] = 0;
      end
      exp_rv = 0;
      exp_rd = 0;
    end else begin
      exp_rv = 0;
      exp_rd = 0;
      for (int c = 0; c < NCH; c++) m_pre[c] = m_state[c];
      if (cfg_valid) begin
        mch  = cfg_addr / STRIDE;
        moff = cfg_addr % STRIDE;
        if (cfg_type == TXN_READ) begin
          exp_rv = 1;
          exp_rd = m_read(mch, moff);
        end else if (mch < NCH) begin
          if (moff inside {32'h0, 32'h4, 32'h8, 32'hC} && m_pre[mch] != 0)
            m_err[mch] = 1;
          else begin
            case (moff)
              32'h00: m_addr[mch] = cfg_data;
              32'h04: m_op[mch]   = cfg_data & 32'h3;
              32'h08: m_size[mch] = cfg_data & 32'hFF;
              32'h0C: if (cfg_data[0]) m_state[mch] = 1;
              32'h10: begin
                if (cfg_data[2]) m_err[mch] = 0;
                if (cfg_data[3]) m_irqp[mch] = 0;
              end
`ifdef CONFIG_CSR_BANK_IRQ_EN
              32'h14: m_irqen[mch] = cfg_data[0];
`endif
              default: ;
            endcase
          end
        end
      end
      for (int c = 0; c < NCH; c++) begin
        if (m_pre[c] == 1 && txn_ready[c]) m_state[c] = 2;
        else if (m_pre[c] == 2 && txn_done[c]) begin
          m_state[c] = 0;
`ifdef CONFIG_CSR_BANK_IRQ_EN
          m_irqp[c] = 1;
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("txn_valid[%0d]", c), txn_valid[c], m_state[c] == 1);
      if (m_state[c] == 1) begin
        check($sformatf("txn_addr[%0d]", c), txn_addr[c], m_addr[c]);
        check($sformatf("txn_op[%0d]", c), txn_op[c], m_op[c]);
        check($sformatf("txn_size[%0d]", c), txn_size[c], m_size[c]);
      end
`ifdef CONFIG_CSR_BANK_IRQ_EN
      check($sformatf("irq[%0d]", c), irq[c], m_irqp[c] & m_irqen[c]);
`endif
    end
    check("cfg_read_valid", cfg_read_valid, exp_rv);
    if (exp_rv) check("cfg_read_data", cfg_read_data, exp_rd);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_wr(input logic [31:0] a, input logic [31:0] d);
    cfg_valid = 1'b1; cfg_type = TXN_WRITE; cfg_addr = a; cfg_data = d;
    tick(1);
    cfg_valid = 1'b0;
  endtask

  task automatic cfg_rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    cfg_valid = 1'b1; cfg_type = TXN_READ; cfg_addr = a; cfg_data = 32'h0;
    tick(1);
    cfg_valid = 1'b0;
    check({name, " valid"}, cfg_read_valid, 1);
    check(name, cfg_read_data, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cfg_valid = 0; cfg_addr = 0; cfg_data = 0; cfg_size = 8'd4; cfg_type = TXN_READ;
    txn_ready = '1; txn_done = '0;
    tick(3);
    check("reset txn_valid", txn_valid, 4'b0000);
    check("reset cfg_read_valid", cfg_read_valid, 0);
    check("reset cfg_read_data", cfg_read_data, 0);
    rst_n = 1'b1;
    tick(1);

    // Program and launch ch0 with downstream stalled
    txn_ready[0] = 1'b0;
    cfg_wr(32'h000, 32'h1000);
    cfg_wr(32'h004, 32'h1);
    cfg_wr(32'h008, 32'h40);
    cfg_wr(32'h00C, 32'h1);
    check("ch0 launch txn_valid", txn_valid[0], 1);
    check("ch0 launch txn_addr", txn_addr[0], 32'h1000);
    check("ch0 launch txn_size", txn_size[0], 32'h40);
    check("ch0 launch txn_op", txn_op[0], 32'h1);
    tick(5);
    check("ch0 stalled txn_valid", txn_valid[0], 1);
    cfg_rd(32'h010, 32'h1, "ch0 status pend");
    cfg_rd(32'h000, 32'h1000, "ch0 addr");
    cfg_rd(32'h004, 32'h1, "ch0 op");
    cfg_rd(32'h008, 32'h40, "ch0 size");
    txn_ready[0] = 1'b1;
    tick(1);
    txn_ready[0] = 1'b0;
    check("ch0 accepted txn_valid", txn_valid[0], 0);
    cfg_rd(32'h010, 32'h2, "ch0 status active");
    txn_done[0] = 1'b1; tick(1); txn_done[0] = 1'b0;
    cfg_rd(32'h010, 32'h0, "ch0 status idle");
    txn_ready[0] = 1'b1;

    // Writes while active are dropped and flag err
    cfg_wr(32'h020, 32'h1111);
    cfg_wr(32'h02C, 32'h1);
    tick(1);
    cfg_wr(32'h020, 32'h2000);
    cfg_rd(32'h020, 32'h1111, "ch1 addr kept");
    cfg_rd(32'h030, 32'h6, "ch1 status err");
    cfg_wr(32'h030, 32'h4);
    cfg_rd(32'h030, 32'h2, "ch1 status err cleared");
    txn_done[1] = 1'b1; tick(1); txn_done[1] = 1'b0;

    // Unmapped accesses
    cfg_rd(32'h078, 32'h0, "ch3 off 0x18");
    cfg_rd(32'h0A0, 32'h0, "ch5 addr");
    cfg_rd(32'h00C, 32'h0, "start reads 0");
    cfg_wr(32'h0A0, 32'hDEAD);
    cfg_wr(32'h018, 32'hBEEF);

    // cfg write on ch0 alongside completion on ch1
    cfg_wr(32'h02C, 32'h1);
    tick(1);
    cfg_valid = 1'b1; cfg_type = TXN_WRITE; cfg_addr = 32'h000; cfg_data = 32'hABC;
    txn_done[1] = 1'b1;
    tick(1);
    cfg_valid = 1'b0; txn_done[1] = 1'b0;
    cfg_rd(32'h000, 32'hABC, "ch0 addr concurrent");
    cfg_rd(32'h030, 32'h0, "ch1 status concurrent done");

    // START in the same cycle as completion is dropped with err
    cfg_wr(32'h02C, 32'h1);
    tick(1);
    cfg_valid = 1'b1; cfg_type = TXN_WRITE; cfg_addr = 32'h02C; cfg_data = 32'h1;
    txn_done[1] = 1'b1;
    tick(1);
    cfg_valid = 1'b0; txn_done[1] = 1'b0;
    check("ch1 start+done txn_valid", txn_valid[1], 0);
    cfg_rd(32'h030, 32'h4, "ch1 status start+done");
    cfg_wr(32'h030, 32'h4);
    cfg_rd(32'h030, 32'h0, "ch1 status cleared");

    // Reset while ch2 pending
    txn_ready[2] = 1'b0;
    cfg_wr(32'h04C, 32'h1);
    check("ch2 pend txn_valid", txn_valid[2], 1);
    #1 rst_n = 1'b0;
    #1 check("async reset txn_valid", txn_valid, 4'b0000);
    check("async reset cfg_read_valid", cfg_read_valid, 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    txn_done[2] = 1'b1; tick(1); txn_done[2] = 1'b0;
    cfg_rd(32'h050, 32'h0, "ch2 status after reset");
    cfg_rd(32'h000, 32'h0, "ch0 addr after reset");
    txn_ready[2] = 1'b1;

`ifdef CONFIG_CSR_BANK_IRQ_EN
    cfg_wr(32'h014, 32'h1);
    cfg_wr(32'h00C, 32'h1);
    tick(1);
    txn_done[0] = 1'b1; tick(1); txn_done[0] = 1'b0;
    check("irq0 raised", irq[0], 1);
    cfg_rd(32'h010, 32'h8, "ch0 status irq_pend");
    tick(3);
    check("irq0 held", irq[0], 1);
    cfg_wr(32'h010, 32'h8);
    check("irq0 cleared", irq[0], 0);
    cfg_rd(32'h014, 32'h1, "ch0 irq_en");
`else
    cfg_wr(32'h014, 32'h1);
    cfg_rd(32'h014, 32'h0, "irq_en unmapped");
    cfg_wr(32'h00C, 32'h1);
    tick(1);
    txn_done[0] = 1'b1; tick(1); txn_done[0] = 1'b0;
    cfg_rd(32'h010, 32'h0, "ch0 status no irq bit");
`endif

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/config_csr_bank.md
CONFIG_CSR_BANK -- requirements
Module: config_csr_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent transaction channels (1..8).
REQ-002 SHALL have parameter CH_STRIDE, default 12'h020, byte address stride between channel register windows.
REQ-003 SHALL have port clk  input  1  single clock, rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports cfg_valid input 1, cfg_addr input paddr_t, cfg_data input data_t, cfg_size input size_t, cfg_type input transaction_t: one uncached config access per cycle when cfg_valid=1.
REQ-006 SHALL have ports cfg_read_data output data_t and cfg_read_valid output 1: read response.
REQ-007 SHALL have ports txn_valid output NUM_CH, txn_ready input NUM_CH: per-channel launch handshake.
REQ-008 SHALL have ports txn_addr output NUM_CH x paddr_t, txn_op output NUM_CH x req_type_t, txn_size output NUM_CH x size_t: launched transaction fields.
REQ-009 SHALL have port txn_done input NUM_CH: one-cycle completion pulse per channel.

Function
REQ-010 Channel c window base = c*CH_STRIDE; offsets 0x0 ADDR (RW), 0x4 OP (RW), 0x8 SIZE (RW), 0xC START (WO, write 1 launches), 0x10 STATUS (RO: [1:0] state, [2] err, [3] irq_pend).
REQ-011 Writes (cfg_valid=1, cfg_type=write) SHALL update the addressed register at the following rising edge; cfg_read_valid stays 0.
REQ-012 Reads SHALL assert cfg_read_valid for exactly one cycle, one cycle after the request, with data zero-extended to data_t.
REQ-013 Reads of unmapped offsets, channels >= NUM_CH, or START SHALL return 0 with cfg_read_valid=1; unmapped writes SHALL be dropped silently.
REQ-014 Per-channel FSM states IDLE(0), PEND(1), ACTIVE(2).
REQ-015 IDLE -> PEND on write START with data bit0=1; txn_valid[c]=1 in PEND the next cycle.
REQ-016 PEND -> ACTIVE on txn_valid[c] & txn_ready[c]; txn_addr/op/size SHALL be held stable throughout PEND.
REQ-017 ACTIVE -> IDLE on txn_done[c]; txn_done in IDLE or PEND SHALL be ignored.
REQ-018 Writes to ADDR/OP/SIZE/START while not IDLE SHALL be dropped and set sticky err; err clears on write of 1 to STATUS bit2.
REQ-019 Channels SHALL operate independently; a cfg access to channel a and txn_done on channel b in the same cycle both take effect.
REQ-020 Write START in the same cycle as txn_done on that channel SHALL be dropped with err set (state not IDLE at that edge).

Reset
REQ-021 On rst_n=0, asynchronously: all channels IDLE, ADDR/OP/SIZE/err/irq_pend = 0, txn_valid = 0, cfg_read_valid = 0, cfg_read_data = 0.
REQ-022 Reset mid-transaction SHALL abandon it; later txn_done pulses for it SHALL be ignored.

Configuration
REQ-023 Macro CONFIG_CSR_BANK_IRQ_EN: when defined, adds port irq output NUM_CH and per-channel IRQ_EN register at offset 0x14 (RW bit0).
REQ-024 With macro: ACTIVE -> IDLE sets irq_pend; irq[c] = irq_pend & IRQ_EN; irq_pend clears on write 1 to STATUS bit3.
REQ-025 Without macro: no irq port, offset 0x14 unmapped, STATUS bit3 reads 0.

Structure
REQ-026 config_pkg SHALL hold paddr_t, data_t, size_t, transaction_t, req_type_t, register offset constants and ch_state_t enum.
REQ-027 Per-channel registers and FSM SHALL be sub-module config_csr_channel, instantiated NUM_CH times; top holds decode and read mux.

Verification
REQ-028 Write ch0 ADDR=0x1000, OP=1, SIZE=0x40, START=1 -> txn_valid[0]=1 next cycle, txn_addr[0]=0x1000, txn_size[0]=0x40.
REQ-029 Hold txn_ready[0]=0 for 5 cycles then 1 -> txn_valid stays 1 with stable fields, STATUS reads 2 after accept, 0 after txn_done.
REQ-030 Write ch1 ADDR=0x2000 while ch1 ACTIVE -> ADDR still reads old value, STATUS bit2=1; write 0x4 to STATUS clears it.
REQ-031 Read ch3 offset 0x18 and channel 5 (NUM_CH=4) -> cfg_read_valid=1 one cycle later, data 0.
REQ-032 Drop rst_n while ch2 PEND -> txn_valid[2]=0 immediately; txn_done[2] after reset leaves STATUS=0.
REQ-033 With CONFIG_CSR_BANK_IRQ_EN, IRQ_EN[0]=1, complete ch0 -> irq[0]=1 until STATUS bit3 written 1.
